// File: rtl/tdc_pkg.sv
// Shared types and helpers for the 10-phase TDC consumer path.
// Event record {coarse, fine}, fine encoder, majority vote helper.
package tdc_pkg;

  localparam int NPHASE   = 10;
  localparam int FINE_W   = 4;
  localparam int COARSE_W = 16;

  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
  } tdc_event_t;

  // Index of the lowest set bit of an edge vector (bit 0 = earliest phase).
  function automatic logic [FINE_W-1:0] fine_encode(input logic [NPHASE-1:0] e);
    logic [FINE_W-1:0] idx;
    idx = '0;
    for (int i = NPHASE - 1; i >= 0; i--) begin
      if (e[i]) idx = FINE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tdc_event_fifo.sv
// First-word-fall-through FIFO of tdc_event_t with occupancy output.
// A write while full is accepted only when a pop happens in the same cycle.
module tdc_event_fifo
  import tdc_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  tdc_event_t               wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output tdc_event_t               rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  tdc_event_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_en & rd_valid;
  assign push     = wr_en & (~full | pop);
  assign rd_data  = mem[rd_ptr];
  assign level    = count;

  // Storage, pointers and occupancy; reset empties the FIFO and clears contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_phase_decoder.sv
// 10-phase TDC snapshot decoder: earliest rising edge -> {coarse, fine} event,
// buffered in a FWFT FIFO and drained over a valid/ready stream.
// Stream handshake: ev_valid stays high and ev_coarse/ev_fine stay stable until
// the cycle where ev_valid & ev_ready are both high; that cycle pops the head.
// Optional build macro TDC_BUBBLE_FILTER_EN adds a majority-of-3 bubble filter
// stage ahead of the edge search (latency to ev_valid 3 cycles instead of 2).
module tdc_phase_decoder
  import tdc_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic [NPHASE-1:0]             phase_smp,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [COARSE_W-1:0]           ev_coarse,
  output logic [FINE_W-1:0]             ev_fine,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          multi_hit,
  output logic [DROP_W-1:0]             drop_cnt
);

  logic [COARSE_W-1:0] coarse;
  logic                prev_msb;
  logic [NPHASE-1:0]   det_snap;
  logic [COARSE_W-1:0] det_coarse;
  logic                det_en;
  logic [NPHASE-1:0]   edge_vec;
  logic                hit;
  logic                multi;
  logic                ev_pend;
  tdc_event_t          ev_data;
  tdc_event_t          head;
  logic                fifo_full;
  logic                pop;
  logic                drop;

  // Free-running coarse counter, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) coarse <= '0;
    else     coarse <= coarse + 1'b1;
  end

`ifdef TDC_BUBBLE_FILTER_EN
  logic                raw_prev_msb;
  logic [NPHASE+1:0]   ext;
  logic [NPHASE-1:0]   filt;
  logic [NPHASE-1:0]   filt_q;
  logic [COARSE_W-1:0] coarse_q;
  logic                en_q;

  assign ext = {phase_smp[NPHASE-1], phase_smp, raw_prev_msb};

  // Majority-of-3 across neighbouring phases removes single-bit bubbles.
  always_comb begin
    filt = '0;
    for (int i = 0; i < NPHASE; i++) filt[i] = maj3(ext[i], ext[i+1], ext[i+2]);
  end

  // Filter stage register; the coarse stamp travels with the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_prev_msb <= 1'b0;
      filt_q       <= '0;
      coarse_q     <= '0;
      en_q         <= 1'b0;
      prev_msb     <= 1'b0;
    end else begin
      raw_prev_msb <= phase_smp[NPHASE-1];
      filt_q       <= filt;
      coarse_q     <= coarse;
      en_q         <= en;
      prev_msb     <= filt_q[NPHASE-1];
    end
  end

  assign det_snap   = filt_q;
  assign det_coarse = coarse_q;
  assign det_en     = en_q;
`else
  // Last phase of the previous snapshot seeds edge detection at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_msb <= 1'b0;
    else     prev_msb <= phase_smp[NPHASE-1];
  end

  assign det_snap   = phase_smp;
  assign det_coarse = coarse;
  assign det_en     = en;
`endif

  assign edge_vec = det_snap & ~{det_snap[NPHASE-2:0], prev_msb};
  assign hit      = det_en & (|edge_vec);
  assign multi    = hit & (|(edge_vec & (edge_vec - 1'b1)));

  // Event stage: registered candidate that is written to the FIFO next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_pend <= 1'b0;
      ev_data <= '0;
    end else begin
      ev_pend        <= hit;
      ev_data.coarse <= det_coarse;
      ev_data.fine   <= fine_encode(edge_vec);
    end
  end

  tdc_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (ev_pend),
    .wr_data  (ev_data),
    .rd_en    (ev_ready),
    .rd_valid (ev_valid),
    .rd_data  (head),
    .level    (fifo_level),
    .full     (fifo_full)
  );

  assign ev_coarse = head.coarse;
  assign ev_fine   = head.fine;
  assign pop       = ev_valid & ev_ready;
  assign drop      = ev_pend & fifo_full & ~pop;

  // Sticky flags and saturating drop counter; clr wins, then this cycle's news applies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      multi_hit <= 1'b0;
      drop_cnt  <= '0;
    end else if (clr) begin
      overflow  <= drop;
      multi_hit <= multi;
      drop_cnt  <= drop ? DROP_W'(1) : '0;
    end else begin
      overflow  <= overflow | drop;
      multi_hit <= multi_hit | multi;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_phase_decoder.sv
// Bench for tdc_phase_decoder: vector table plus hand-written corner sequences,
// scoreboard queue of expected {coarse, fine} events popped on each handshake.
module tb_tdc_phase_decoder;

  localparam int NPHASE   = 10;
  localparam int COARSE_W = 16;
  localparam int LVL_W    = 5;
`ifdef TDC_BUBBLE_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                clk;
  logic                rst;
  logic                en;
  logic                clr;
  logic [NPHASE-1:0]   phase_smp;
  logic                ev_valid;
  logic                ev_ready;
  logic [COARSE_W-1:0] ev_coarse;
  logic [3:0]          ev_fine;
  logic [LVL_W-1:0]    fifo_level;
  logic                overflow;
  logic                multi_hit;
  logic [7:0]          drop_cnt;

  int tests_run;
  int tests_failed;

  logic [COARSE_W-1:0] ref_coarse;
  logic [19:0]         exp_q[$];

  typedef struct {
    logic [NPHASE-1:0] snap;
    logic              en;
    logic              ev;
    logic [3:0]        fine;
    logic              multi;
  } vec_t;
  vec_t tbl[16];

  tdc_phase_decoder #(.FIFO_DEPTH(16), .DROP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .phase_smp  (phase_smp),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_coarse  (ev_coarse),
    .ev_fine    (ev_fine),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .multi_hit  (multi_hit),
    .drop_cnt   (drop_cnt)
  );

  // ---------------- clock / reset / reference cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) ref_coarse <= '0;
    else     ref_coarse <= ref_coarse + 1'b1;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_event: got coarse=%0d fine=%0d expected none", ev_coarse, ev_fine);
      end else begin
        check("event", {12'd0, ev_coarse, ev_fine}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_snap(input logic [NPHASE-1:0] snap, input logic en_v,
                            input logic exp_ev, input logic [3:0] exp_fine);
    phase_smp = snap;
    en        = en_v;
    if (exp_ev) exp_q.push_back({ref_coarse, exp_fine});
    step();
  endtask

  task automatic drain();
    int n;
    ev_ready  = 1'b1;
    phase_smp = '0;
    n = 0;
    while ((exp_q.size() != 0 || ev_valid) && n < 200) begin
      step();
      n++;
    end
    check("drain_done", {31'd0, (exp_q.size() == 0 && !ev_valid)}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [COARSE_W-1:0] exp_c;
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; phase_smp = '0; ev_ready = 1'b0;

    tbl[0]  = '{10'h000, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{10'h3F8, 1'b1, 1'b1, 4'd3, 1'b0};
    tbl[2]  = '{10'h000, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{10'h3FF, 1'b1, 1'b1, 4'd0, 1'b0};
    tbl[4]  = '{10'h3FF, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[5]  = '{10'h000, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[6]  = '{10'h0F0, 1'b1, 1'b1, 4'd4, 1'b0};
    tbl[7]  = '{10'h000, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[8]  = '{10'h303, 1'b1, 1'b1, 4'd0, 1'b1};
    tbl[9]  = '{10'h00C, 1'b1, 1'b1, 4'd2, 1'b1};
    tbl[10] = '{10'h001, 1'b0, 1'b0, 4'd0, 1'b1};
    tbl[11] = '{10'h200, 1'b1, 1'b1, 4'd9, 1'b1};
    tbl[12] = '{10'h001, 1'b1, 1'b0, 4'd0, 1'b1};
    tbl[13] = '{10'h0E7, 1'b1, 1'b1, 4'd0, 1'b1};
    tbl[14] = '{10'h300, 1'b1, 1'b1, 4'd8, 1'b1};
    tbl[15] = '{10'h000, 1'b1, 1'b0, 4'd0, 1'b1};

    // Reset state
    repeat (3) step();
    check("rst_ev_valid",  {31'd0, ev_valid},   32'd0);
    check("rst_level",     {27'd0, fifo_level}, 32'd0);
    check("rst_overflow",  {31'd0, overflow},   32'd0);
    check("rst_multi_hit", {31'd0, multi_hit},  32'd0);
    check("rst_drop_cnt",  {24'd0, drop_cnt},   32'd0);
    check("rst_ev_coarse", {16'd0, ev_coarse},  32'd0);
    check("rst_ev_fine",   {28'd0, ev_fine},    32'd0);
    rst = 1'b0;
    ev_ready = 1'b1;

    // Latency of a single event into an empty FIFO
    drive_snap(10'h000, 1'b1, 1'b0, 4'd0);
    exp_c = ref_coarse;
    drive_snap(10'h3F8, 1'b1, 1'b1, 4'd3);
    phase_smp = '0;
    for (int k = 1; k <= LAT; k++) begin
      check("lat_valid", {31'd0, ev_valid}, {31'd0, (k == LAT)});
      if (k < LAT) step();
    end
    check("lat_coarse", {16'd0, ev_coarse}, {16'd0, exp_c});
    check("lat_fine",   {28'd0, ev_fine},   32'd3);
    drain();

    // Vector table; multi_hit appears LAT-1 cycles after the snapshot
    for (int i = 0; i < 16; i++) begin
      drive_snap(tbl[i].snap, tbl[i].en, tbl[i].ev, tbl[i].fine);
      if (i - (LAT - 2) >= 0)
        check("tbl_multi_hit", {31'd0, multi_hit}, {31'd0, tbl[i - (LAT - 2)].multi});
    end
    drain();

    // Fill with consumer stalled: 20 hits, 16 held, 4 dropped
    ev_ready = 1'b0;
    for (int j = 0; j < 20; j++) begin
      drive_snap(10'h3FF, 1'b1, (j < 16), 4'd0);
      drive_snap(10'h000, 1'b1, 1'b0, 4'd0);
    end
    repeat (LAT + 1) step();
    check("full_level",    {27'd0, fifo_level}, 32'd16);
    check("full_overflow", {31'd0, overflow},   32'd1);
    check("full_drop_cnt", {24'd0, drop_cnt},   32'd4);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_overflow", {31'd0, overflow},   32'd0);
    check("clr_drop_cnt", {24'd0, drop_cnt},   32'd0);
    check("clr_level",    {27'd0, fifo_level}, 32'd16);

    // Full FIFO, write coincides with a pop: nothing lost
    drive_snap(10'h3FF, 1'b1, 1'b1, 4'd0);
    phase_smp = '0;
    repeat (LAT - 2) step();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    check("wrpop_level",    {27'd0, fifo_level}, 32'd16);
    check("wrpop_overflow", {31'd0, overflow},   32'd0);
    check("wrpop_drop_cnt", {24'd0, drop_cnt},   32'd0);

    // One drop, then clr in the same cycle as a second drop
    drive_snap(10'h3FF, 1'b1, 1'b0, 4'd0);
    drive_snap(10'h000, 1'b1, 1'b0, 4'd0);
    repeat (LAT) step();
    check("drop1_cnt", {24'd0, drop_cnt}, 32'd1);
    drive_snap(10'h3FF, 1'b1, 1'b0, 4'd0);
    phase_smp = '0;
    repeat (LAT - 2) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clrdrop_overflow", {31'd0, overflow}, 32'd1);
    check("clrdrop_cnt",      {24'd0, drop_cnt}, 32'd1);
    drain();
    check("drained_level", {27'd0, fifo_level}, 32'd0);

    // Reset in the middle of traffic discards everything
    ev_ready = 1'b0;
    drive_snap(10'h3FF, 1'b1, 1'b0, 4'd0);
    drive_snap(10'h000, 1'b1, 1'b0, 4'd0);
    drive_snap(10'h3FF, 1'b1, 1'b0, 4'd0);
    phase_smp = '0;
    rst = 1'b1;
    step();
    check("midrst_level",    {27'd0, fifo_level}, 32'd0);
    check("midrst_ev_valid", {31'd0, ev_valid},   32'd0);
    check("midrst_overflow", {31'd0, overflow},   32'd0);
    check("midrst_drop_cnt", {24'd0, drop_cnt},   32'd0);
    rst = 1'b0;
    step();
    check("midrst_idle_level", {27'd0, fifo_level}, 32'd0);

    // en dropped right after a hit: the in-flight event still arrives
    drive_snap(10'h3FF, 1'b1, 1'b1, 4'd0);
    drive_snap(10'h000, 1'b0, 1'b0, 4'd0);
    drive_snap(10'h3FF, 1'b0, 1'b0, 4'd0);
    drive_snap(10'h000, 1'b0, 1'b0, 4'd0);
    drain();

`ifdef TDC_BUBBLE_FILTER_EN
    // Bubble at bit 4 is voted away, earliest edge is phase 0
    en = 1'b1;
    drive_snap(10'h000, 1'b1, 1'b0, 4'd0);
    exp_c = ref_coarse;
    drive_snap(10'h3EF, 1'b1, 1'b1, 4'd0);
    phase_smp = '0;
    for (int k = 1; k <= 3; k++) begin
      check("bubble_valid", {31'd0, ev_valid}, {31'd0, (k == 3)});
      if (k < 3) step();
    end
    check("bubble_coarse", {16'd0, ev_coarse}, {16'd0, exp_c});
    check("bubble_fine",   {28'd0, ev_fine},   32'd0);
    drain();
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
